mgmt_bridge: RTL

- Parametrised successor to the 16→32 management port.
- Turns a narrow, strobe-driven CPU I/O window (IN_W) into full-width transactions on the internal management bus (OUT_W), with an address pointer that auto-advances.
- Adds: configurable width ratio, selectable increment mode, byte enables, and a flush of partially written words when the session ends.
- Sits between the soc I/O decoder and management-side register files and FIFOs.

---
 rtl/mgmt_bridge_pkg.sv | 19 +
 rtl/mgmt_bridge_if.sv | 41 ++++
 rtl/mgmt_bridge_pack.sv | 87 ++++++++
 rtl/mgmt_bridge.sv | 133 +++++++++++++
 4 files changed

// File: rtl/mgmt_bridge_pkg.sv
// mgmt_bridge_pkg: shared constants and width helpers for the management bridge.
//   INC_*       : address increment modes applied after each full-word access
//   calc_ratio  : number of CPU slices per management word (R)
//   calc_be_w   : byte-enable width of the management word
package mgmt_bridge_pkg;

  localparam int unsigned INC_HOLD = 0;
  localparam int unsigned INC_SAT  = 1;
  localparam int unsigned INC_WRAP = 2;

  function automatic int unsigned calc_ratio(input int unsigned out_w, input int unsigned in_w);
    return out_w / in_w;
  endfunction

  function automatic int unsigned calc_be_w(input int unsigned out_w);
    return out_w / 8;
  endfunction

endpackage

// File: rtl/mgmt_bridge_if.sv
// mgmt_bridge_if: CPU-window and management-bus signals of the bridge.
//   in_*   : narrow strobe-driven CPU I/O window
//   out_*  : full-width management bus
//   busy   : bridge holds a partial word or a pending pulse
//   slave  : bridge view; master : CPU decoder / management side view
interface mgmt_bridge_if
  import mgmt_bridge_pkg::*;
#(
  parameter int unsigned IN_W   = 16,
  parameter int unsigned OUT_W  = 32,
  parameter int unsigned ADDR_W = 8
);
  localparam int unsigned BE_W = calc_be_w(OUT_W);

  logic [15:0]       in_address;
  logic              in_active;
  logic              in_read;
  logic [IN_W-1:0]   in_readdata;
  logic              in_write;
  logic [IN_W-1:0]   in_writedata;
  logic [ADDR_W-1:0] out_address;
  logic [OUT_W-1:0]  out_readdata;
  logic              out_read;
  logic              out_write;
  logic [OUT_W-1:0]  out_writedata;
  logic [BE_W-1:0]   out_byteenable;
  logic              busy;

  modport slave (
    input  in_address, in_active, in_read, in_write, in_writedata, out_readdata,
    output in_readdata, out_address, out_read, out_write, out_writedata,
           out_byteenable, busy
  );

  modport master (
    output in_address, in_active, in_read, in_write, in_writedata, out_readdata,
    input  in_readdata, out_address, out_read, out_write, out_writedata,
           out_byteenable, busy
  );

endinterface

// File: rtl/mgmt_bridge_pack.sv
// mgmt_bridge_pack: collects CPU write slices into a management word.
//   i_wr / i_idx / i_data : store i_data into slice i_idx and mark it written
//   i_full                : this write completes the word; emit it with all bytes enabled
//   i_flush               : emit the partial word, enabling only written slices
//   i_clear               : drop any collected slices
//   o_writedata / o_byteenable : registered management write payload
//   o_mask_any            : at least one slice of the current word has been written
module mgmt_bridge_pack #(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = 32,
  parameter int unsigned R     = 2,
  parameter int unsigned IDX_W = 1,
  parameter int unsigned BE_W  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_wr,
  input  logic [IDX_W-1:0] i_idx,
  input  logic [IN_W-1:0]  i_data,
  input  logic             i_full,
  input  logic             i_flush,
  input  logic             i_clear,
  output logic [OUT_W-1:0] o_writedata,
  output logic [BE_W-1:0]  o_byteenable,
  output logic             o_mask_any
);
  localparam int unsigned BPS = IN_W / 8;

  logic [OUT_W-1:0] r_slices;
  logic [R-1:0]     r_mask;
  logic [OUT_W-1:0] r_writedata;
  logic [BE_W-1:0]  r_byteenable;

  logic [OUT_W-1:0] w_slices_upd;
  logic [R-1:0]     w_mask_upd;
  logic [OUT_W-1:0] w_flush_data;
  logic [BE_W-1:0]  w_mask_be;

  // Slice store for the current strobe, plus the flush view with unwritten slices zeroed
  always_comb begin
    w_slices_upd = r_slices;
    w_mask_upd   = r_mask;
    w_flush_data = '0;
    w_mask_be    = '0;
    if (i_wr) begin
      w_slices_upd[int'(i_idx)*IN_W +: IN_W] = i_data;
      w_mask_upd[i_idx]                       = 1'b1;
    end
    for (int s = 0; s < int'(R); s++) begin
      if (r_mask[s]) w_flush_data[s*IN_W +: IN_W] = r_slices[s*IN_W +: IN_W];
    end
    for (int b = 0; b < int'(BE_W); b++) begin
      w_mask_be[b] = r_mask[b / int'(BPS)];
    end
  end

  // Collect slices; emitting or clearing starts a fresh word
  always_ff @(posedge clk) begin
    if (reset) begin
      r_slices     <= '0;
      r_mask       <= '0;
      r_writedata  <= '0;
      r_byteenable <= '0;
    end else if (i_full) begin
      r_writedata  <= w_slices_upd;
      r_byteenable <= '1;
      r_slices     <= '0;
      r_mask       <= '0;
    end else if (i_flush) begin
      r_writedata  <= w_flush_data;
      r_byteenable <= w_mask_be;
      r_slices     <= '0;
      r_mask       <= '0;
    end else if (i_clear) begin
      r_slices     <= '0;
      r_mask       <= '0;
    end else if (i_wr) begin
      r_slices     <= w_slices_upd;
      r_mask       <= w_mask_upd;
    end
  end

  assign o_writedata  = r_writedata;
  assign o_byteenable = r_byteenable;
  assign o_mask_any   = |r_mask;

endmodule

// File: rtl/mgmt_bridge.sv
// mgmt_bridge: narrow CPU I/O window to full-width management bus bridge.
//   clk, reset : system clock, synchronous active-high reset
//   bus        : mgmt_bridge_if slave view (CPU window in_*, management bus out_*, busy)
// Each CPU strobe covers one IN_W slice of an OUT_W word; completing a word issues a
// one-cycle out_read/out_write pulse, after which the address steps per INC_MODE.
module mgmt_bridge
  import mgmt_bridge_pkg::*;
#(
  parameter int unsigned IN_W     = 16,
  parameter int unsigned OUT_W    = 32,
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned INC_MODE = INC_SAT
) (
  input logic           clk,
  input logic           reset,
  mgmt_bridge_if.slave  bus
);
  localparam int unsigned R     = calc_ratio(OUT_W, IN_W);
  localparam int unsigned BE_W  = calc_be_w(OUT_W);
  localparam int unsigned IDX_W = (R > 1) ? $clog2(R) : 1;

  logic [IDX_W-1:0]  r_idx;
  logic [ADDR_W-1:0] r_addr;
  logic              r_out_read;
  logic              r_out_write;
  logic              r_step;
  logic              r_active_q;
  logic [OUT_W-1:0]  r_rd_buf;

  logic [IDX_W-1:0]  w_idx_nxt;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic              w_out_read_nxt;
  logic              w_out_write_nxt;
  logic              w_step_nxt;
  logic              w_wr;
  logic              w_rd;
  logic              w_strobe;
  logic              w_last;
  logic              w_flush;
  logic              w_mask_any;

  function automatic logic [ADDR_W-1:0] step_addr(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] s;
    s = a;
    if (INC_MODE == INC_SAT)       s = (a == '1) ? a : a + ADDR_W'(1);
    else if (INC_MODE == INC_WRAP) s = a + ADDR_W'(1);
    return s;
  endfunction

  // Next-state: slice index, address pointer and pulse scheduling
  always_comb begin
    w_wr     = bus.in_active & bus.in_write;
    w_rd     = bus.in_active & bus.in_read & ~bus.in_write;  // write wins a collision
    w_strobe = w_wr | w_rd;
    w_last   = (r_idx == IDX_W'(R - 1));
    // Session closing with a partially written word pending
    w_flush  = r_active_q & ~bus.in_active & (r_idx != '0) & w_mask_any;

    w_idx_nxt       = r_idx;
    w_addr_nxt      = r_addr;
    w_out_read_nxt  = 1'b0;
    w_out_write_nxt = 1'b0;
    w_step_nxt      = 1'b0;

    if (!bus.in_active) begin
      w_idx_nxt  = '0;
      // Hold the address during the flush pulse; reload resumes the cycle after
      w_addr_nxt = w_flush ? r_addr : bus.in_address[ADDR_W-1:0];
    end else begin
      if (r_step)   w_addr_nxt = step_addr(r_addr);
      if (w_strobe) w_idx_nxt  = w_last ? '0 : r_idx + IDX_W'(1);
    end

    w_out_read_nxt  = w_rd & w_last;
    w_out_write_nxt = (w_wr & w_last) | w_flush;
    w_step_nxt      = w_strobe & w_last;
  end

  // Control registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_idx       <= '0;
      r_addr      <= '0;
      r_out_read  <= 1'b0;
      r_out_write <= 1'b0;
      r_step      <= 1'b0;
      r_active_q  <= 1'b0;
    end else begin
      r_idx       <= w_idx_nxt;
      r_addr      <= w_addr_nxt;
      r_out_read  <= w_out_read_nxt;
      r_out_write <= w_out_write_nxt;
      r_step      <= w_step_nxt;
      r_active_q  <= bus.in_active;
    end
  end

  // Read snapshot tracks the bus only between words, so multi-slice reads stay coherent
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_buf <= '0;
    end else if ((r_idx == '0) && !r_out_read && !r_out_write) begin
      r_rd_buf <= bus.out_readdata;
    end
  end

  mgmt_bridge_pack #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W),
    .R     (R),
    .IDX_W (IDX_W),
    .BE_W  (BE_W)
  ) u_pack (
    .clk          (clk),
    .reset        (reset),
    .i_wr         (w_wr),
    .i_idx        (r_idx),
    .i_data       (bus.in_writedata),
    .i_full       (w_wr & w_last),
    .i_flush      (w_flush),
    .i_clear      (~bus.in_active),
    .o_writedata  (bus.out_writedata),
    .o_byteenable (bus.out_byteenable),
    .o_mask_any   (w_mask_any)
  );

  assign bus.in_readdata = r_rd_buf[int'(r_idx)*IN_W +: IN_W];
  assign bus.out_address = r_addr;
  assign bus.out_read    = r_out_read;
  assign bus.out_write   = r_out_write;
  assign bus.busy        = (r_idx != '0) | r_out_read | r_out_write | r_step;

endmodule
